irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt controller that feeds the jump/control block of the 16-bit processor.
- Synchronizes and edge-detects external interrupt lines, latches pending requests and applies a CPU-written enable mask.
- Selects the highest-priority eligible request and drives the single `interrupt` line plus an ISR vector address to the jump/control block.
- Tracks the in-service request until the program executes RETI.
- Single-level: no nesting or preemption.

Parameters:
- N_IRQ, 4, number of interrupt lines (fixed at 4 for this revision; id width 2).
- VEC_BASE, 16'h0100, vector address of irq 0.
- VEC_STRIDE, 16'h0004, address spacing between consecutive vectors.
- OP_RETI, 6'h3F, opcode value that ends an ISR.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_in  input  4  raw interrupt lines, asynchronous, rising-edge significant.
- mask_wr  input  1  write strobe for the enable mask.
- mask_data  input  4  new mask value; bit=1 enables that irq.
- op  input  6  opcode of the instruction in execute.
- op_valid  input  1  op is valid this cycle (one-cycle strobe per instruction).
- int_ack  input  1  jump/control block has taken the ISR jump.
- interrupt  output  1  request to the jump/control block.
- isr_addr  output  16  vector address for the active request.
- active_id  output  2  id of the request in REQ/SERVICE.
- pending  output  4  pending register.
- mask  output  4  enable mask register.
- in_service  output  4  one-hot in-service register.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, immediate): all registers cleared.
  - Values: state=IDLE, interrupt=0, isr_addr=16'h0000, active_id=0, pending=0, mask=0 (all disabled), in_service=0, busy=0.
  - Synchronizer and edge flops cleared.
  - Reset mid-operation aborts any REQ/SERVICE without side effects.
- Input path, per bit:
  - 2-flop synchronizer (s1, s2), then a delay flop s3.
  - edge = s2 & ~s3.
  - pending[i] set on the clock following an edge.
  - A line held high produces one edge only.
  - irq_in rising before edge t0 → pending visible after edge t2 (3 clocks).
- Mask:
  - On mask_wr, mask <= mask_data at the next edge.
  - The new mask takes effect for arbitration the cycle after the write.
  - Masked pending bits are retained, not dropped.
- eligible = pending & mask. Priority: lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If eligible != 0 → REQ at the next edge.
  - On that edge: active_id <= winning id; isr_addr <= VEC_BASE + active_id*VEC_STRIDE (16-bit, modulo 2^16); interrupt <= 1.
- REQ:
  - interrupt held at 1.
  - active_id and isr_addr frozen; a higher-priority arrival or a mask change does not alter or withdraw the request.
  - On int_ack → SERVICE at the next edge: pending[active_id] cleared, in_service[active_id] set, interrupt <= 0.
- SERVICE:
  - op_valid && op==OP_RETI → IDLE at the next edge, in_service cleared.
  - Other ops ignored.
  - isr_addr and active_id hold their last values.
- After RETI, IDLE re-arbitrates. Minimum one IDLE cycle between RETI and the next interrupt assertion.
- Ignored events:
  - int_ack outside REQ is ignored.
  - RETI outside SERVICE is ignored.
- Simultaneous events:
  - A new edge on the same bit in the cycle pending is cleared by ack: set wins, pending stays 1.
  - Edges on other bits during REQ/SERVICE accumulate in pending.
- Latency:
  - Eligible in IDLE → interrupt=1 after one clock.
  - int_ack → interrupt=0 after one clock.
- busy = (state != IDLE), registered with state.

Test Plan:
1. Reset and mask:
   - Stimulus: assert reset mid-SERVICE.
   - Required: all outputs 0 immediately; after release, state IDLE with pending=0.
2. Single request:
   - Stimulus: mask=4'b0100, pulse irq_in[2].
   - Required: pending=4'b0100 after 3 clocks; interrupt=1 next clock with isr_addr=16'h0108, active_id=2.
   - Then: int_ack → interrupt=0, pending=0, in_service=4'b0100.
   - Then: op=6'h3F with op_valid → in_service=0, busy=0.
3. Priority:
   - Stimulus: mask=4'hF, irq_in[3] and irq_in[1] rise together.
   - Required: first vector 16'h0104 (id 1). After ack and RETI, second request gives isr_addr=16'h010C (id 3).
4. Masking:
   - Stimulus: mask=0, pulse irq_in[0].
   - Required: pending=4'b0001, interrupt stays 0.
   - Then: write mask=4'b0001 → interrupt=1 two clocks after mask_wr, isr_addr=16'h0100.
5. No preemption:
   - Stimulus: in REQ for id 3, irq_in[0] rises.
   - Required: isr_addr stays 16'h010C until ack; pending[0]=1 retained; id 0 served after RETI.
6. Simultaneous set/clear and stray strobes:
   - Stimulus: new edge on irq 2 in the same cycle as ack of id 2.
   - Required: pending[2]=1 after ack.
   - Stimulus: int_ack in IDLE, or RETI in REQ.
   - Required: no state change.

Source files
------------

// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
//
// Single-level interrupt controller for the 16-bit processor's jump/control
// block. Raw interrupt lines are synchronised and rising-edge detected. Each
// edge latches a pending bit, and a CPU-written enable mask gates which
// pending bits may be arbitrated. The lowest eligible index wins.
//
// The winning request is presented on `interrupt` with its vector address.
// It stays in service until the program executes RETI. There is no nesting
// and no preemption.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   irq_in     in   4   raw interrupt lines (asynchronous, rising edge counts)
//   mask_wr    in   1   enable-mask write strobe
//   mask_data  in   4   new enable mask (1 = enabled)
//   op         in   6   opcode of the instruction in execute
//   op_valid   in   1   op is valid this cycle
//   int_ack    in   1   jump/control block has taken the ISR jump
//   interrupt  out  1   request to the jump/control block
//   isr_addr   out  16  vector address of the active request
//   active_id  out  2   id of the request in REQ/SERVICE
//   pending    out  4   pending register
//   mask       out  4   enable-mask register
//   in_service out  4   one-hot in-service register
//   busy       out  1   controller is not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module irq_sequencer #(
    parameter int          N_IRQ      = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0100,
    parameter logic [15:0] VEC_STRIDE = 16'h0004,
    parameter logic [5:0]  OP_RETI    = 6'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] mask_data,
    input  logic [5:0]       op,
    input  logic             op_valid,
    input  logic             int_ack,
    output logic             interrupt,
    output logic [15:0]      isr_addr,
    output logic [1:0]       active_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] in_service,
    output logic             busy
);

    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;

    logic [N_IRQ-1:0] sync_p0;
    logic [N_IRQ-1:0] sync_p1;
    logic [N_IRQ-1:0] dly_p2;
    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] id_onehot;
    logic [N_IRQ-1:0] pend_clr;
    logic [ID_W-1:0]  win_id;

    // Vector address wraps modulo 2^16.
    function automatic logic [15:0] vec_addr(input logic [ID_W-1:0] id);
        return VEC_BASE + (VEC_STRIDE * {{(16-ID_W){1'b0}}, id});
    endfunction

    // Stage 0/1: two-flop synchroniser. Stage 2: delay flop for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            dly_p2  <= '0;
        end else begin
            sync_p0 <= irq_in;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
        end
    end

    // A line held high yields exactly one edge because dly_p2 catches up.
    assign edge_det = sync_p1 & ~dly_p2;
    assign eligible = pending & mask;

    // Lowest index has priority: scan from the top so the lowest set bit
    // is written last.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        id_onehot            = '0;
        id_onehot[active_id] = 1'b1;
    end

    // Acknowledge clears the served pending bit. A coincident new edge on
    // the same bit is OR-ed in afterwards, so the set wins.
    always_comb begin
        pend_clr = '0;
        if (state == REQ && int_ack) begin
            pend_clr = id_onehot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            interrupt  <= 1'b0;
            isr_addr   <= 16'h0000;
            active_id  <= '0;
            pending    <= '0;
            mask       <= '0;
            in_service <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | edge_det;

            if (mask_wr) begin
                mask <= mask_data;
            end

            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state     <= REQ;
                        busy      <= 1'b1;
                        active_id <= win_id;
                        isr_addr  <= vec_addr(win_id);
                        interrupt <= 1'b1;
                    end
                end
                // Request is frozen until acknowledged; later arrivals and
                // mask writes only affect the next arbitration.
                REQ: begin
                    if (int_ack) begin
                        state      <= SERVICE;
                        in_service <= id_onehot;
                        interrupt  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (op_valid && op == OP_RETI) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        in_service <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    interrupt  <= 1'b0;
                    in_service <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
`timescale 1ns/1ps

module tb_irq_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic [5:0]  op;
    logic        op_valid;
    logic        int_ack;
    logic        interrupt;
    logic [15:0] isr_addr;
    logic [1:0]  active_id;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic [3:0]  in_service;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    irq_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .op         (op),
        .op_valid   (op_valid),
        .int_ack    (int_ack),
        .interrupt  (interrupt),
        .isr_addr   (isr_addr),
        .active_id  (active_id),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It is built from the behavioural rules:
    //   - a rising line is latched as pending three clocks later;
    //   - an idle controller picks the lowest eligible id;
    //   - acknowledge moves that id into service;
    //   - RETI ends the service.
    // hist[k] holds the irq_in value sampled k+1 clocks ago.
    logic [3:0]  hist [3];
    logic [3:0]  m_pending, m_mask, m_insvc;
    logic [15:0] m_addr;
    logic [1:0]  m_id;
    logic        m_int;
    bit          m_req, m_isr;
    logic [3:0]  m_rise, m_elig, m_low, m_clr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist[0] = 4'h0; hist[1] = 4'h0; hist[2] = 4'h0;
            m_pending = 4'h0; m_mask = 4'h0; m_insvc = 4'h0;
            m_addr = 16'h0000; m_id = 2'd0; m_int = 1'b0;
            m_req = 1'b0; m_isr = 1'b0;
        end else begin
            m_rise = hist[1] & ~hist[2];
            m_clr  = 4'h0;
            if (!m_req && !m_isr) begin
                m_elig = m_pending & m_mask;
                if (m_elig != 4'h0) begin
                    m_low  = m_elig & (~m_elig + 4'd1);
                    m_id   = 2'($countones(m_low - 4'd1));
                    m_addr = 16'h0100 + 16'(m_id) * 16'd4;
                    m_int  = 1'b1;
                    m_req  = 1'b1;
                end
            end else if (m_req) begin
                if (int_ack) begin
                    m_clr   = 4'b0001 << m_id;
                    m_insvc = m_clr;
                    m_int   = 1'b0;
                    m_req   = 1'b0;
                    m_isr   = 1'b1;
                end
            end else if (op_valid && op == 6'h3F) begin
                m_isr   = 1'b0;
                m_insvc = 4'h0;
            end
            m_pending = (m_pending & ~m_clr) | m_rise;
            if (mask_wr) m_mask = mask_data;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_in;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_wr = 1'b1; mask_data = m;
        cyc();
        mask_wr = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] bits);
        irq_in = bits;
        cyc();
        irq_in = 4'h0;
    endtask

    task automatic finish_isr();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0; op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        cyc();
    endtask

    task automatic test_reset();
        n_tests++;
        if ({interrupt, isr_addr, active_id, pending, mask, in_service, busy} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {interrupt, isr_addr, active_id, pending, mask, in_service, busy});
        end
        reset = 1'b0;
        cyc();
        n_tests++;
        if (busy !== 1'b0 || pending !== 4'h0 || mask !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b pending=%b mask=%b want 0/0/0", busy, pending, mask);
        end
    endtask

    task automatic test_single();
        set_mask(4'b0100);
        pulse(4'b0100);
        cyc();
        n_tests++;
        if (pending !== 4'b0000) begin
            n_fail++; $display("FAIL single_pending_early: got %b want 0000", pending);
        end
        cyc();
        n_tests++;
        if (pending !== 4'b0100 || interrupt !== 1'b0) begin
            n_fail++; $display("FAIL single_pending: got %b int=%b want 0100 int=0", pending, interrupt);
        end
        cyc();
        n_tests++;
        if (interrupt !== 1'b1 || isr_addr !== 16'h0108 || active_id !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_request: int=%b addr=%h id=%0d busy=%b want 1 0108 2 1",
                     interrupt, isr_addr, active_id, busy);
        end
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_tests++;
        if (interrupt !== 1'b0 || pending !== 4'h0 || in_service !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ack: int=%b pending=%b insvc=%b want 0 0000 0100",
                     interrupt, pending, in_service);
        end
        op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        n_tests++;
        if (in_service !== 4'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_reti: insvc=%b busy=%b want 0000 0", in_service, busy);
        end
    endtask

    task automatic test_priority();
        set_mask(4'hF);
        pulse(4'b1010);
        cyc(); cyc(); cyc();
        n_tests++;
        if (interrupt !== 1'b1 || isr_addr !== 16'h0104 || active_id !== 2'd1) begin
            n_fail++;
            $display("FAIL prio_first: int=%b addr=%h id=%0d want 1 0104 1", interrupt, isr_addr, active_id);
        end
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_tests++;
        if (pending !== 4'b1000 || interrupt !== 1'b0) begin
            n_fail++; $display("FAIL prio_ack: pending=%b int=%b want 1000 0", pending, interrupt);
        end
        op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        n_tests++;
        if (busy !== 1'b0 || interrupt !== 1'b0) begin
            n_fail++; $display("FAIL prio_idle_gap: busy=%b int=%b want 0 0", busy, interrupt);
        end
        cyc();
        n_tests++;
        if (interrupt !== 1'b1 || isr_addr !== 16'h010C || active_id !== 2'd3) begin
            n_fail++;
            $display("FAIL prio_second: int=%b addr=%h id=%0d want 1 010c 3", interrupt, isr_addr, active_id);
        end
        finish_isr();
    endtask

    task automatic test_masking();
        set_mask(4'h0);
        pulse(4'b0001);
        cyc(); cyc(); cyc(); cyc();
        n_tests++;
        if (pending !== 4'b0001 || interrupt !== 1'b0) begin
            n_fail++; $display("FAIL mask_hold: pending=%b int=%b want 0001 0", pending, interrupt);
        end
        mask_wr = 1'b1; mask_data = 4'b0001;
        cyc();
        mask_wr = 1'b0;
        n_tests++;
        if (interrupt !== 1'b0 || mask !== 4'b0001) begin
            n_fail++; $display("FAIL mask_write: int=%b mask=%b want 0 0001", interrupt, mask);
        end
        cyc();
        n_tests++;
        if (interrupt !== 1'b1 || isr_addr !== 16'h0100 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL mask_enable: int=%b addr=%h id=%0d want 1 0100 0", interrupt, isr_addr, active_id);
        end
        finish_isr();
    endtask

    task automatic test_no_preempt();
        set_mask(4'hF);
        pulse(4'b1000);
        cyc(); cyc(); cyc();
        pulse(4'b0001);
        cyc(); cyc();
        n_tests++;
        if (pending !== 4'b1001 || isr_addr !== 16'h010C || active_id !== 2'd3 || interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL nopre_req: pending=%b addr=%h id=%0d int=%b want 1001 010c 3 1",
                     pending, isr_addr, active_id, interrupt);
        end
        set_mask(4'b0001);
        cyc();
        n_tests++;
        if (isr_addr !== 16'h010C || interrupt !== 1'b1) begin
            n_fail++; $display("FAIL nopre_maskchg: addr=%h int=%b want 010c 1", isr_addr, interrupt);
        end
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_tests++;
        if (pending !== 4'b0001 || in_service !== 4'b1000) begin
            n_fail++; $display("FAIL nopre_ack: pending=%b insvc=%b want 0001 1000", pending, in_service);
        end
        op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        cyc();
        n_tests++;
        if (interrupt !== 1'b1 || isr_addr !== 16'h0100 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL nopre_next: int=%b addr=%h id=%0d want 1 0100 0", interrupt, isr_addr, active_id);
        end
        finish_isr();
        set_mask(4'hF);
    endtask

    task automatic test_simultaneous();
        pulse(4'b0100);
        cyc(); cyc(); cyc();
        // The new edge lands at the same clock as the acknowledge.
        irq_in = 4'b0100;
        cyc();
        irq_in = 4'b0000;
        cyc();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        n_tests++;
        if (pending !== 4'b0100 || in_service !== 4'b0100 || interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_set_wins: pending=%b insvc=%b int=%b want 0100 0100 0",
                     pending, in_service, interrupt);
        end
        op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        cyc();
        n_tests++;
        if (interrupt !== 1'b1 || active_id !== 2'd2) begin
            n_fail++; $display("FAIL simul_reserve: int=%b id=%0d want 1 2", interrupt, active_id);
        end
        finish_isr();
    endtask

    task automatic test_stray();
        int_ack = 1'b1; op = 6'h3F; op_valid = 1'b1;
        cyc();
        int_ack = 1'b0; op_valid = 1'b0; op = 6'h00;
        n_tests++;
        if (busy !== 1'b0 || interrupt !== 1'b0 || in_service !== 4'h0) begin
            n_fail++;
            $display("FAIL stray_idle: busy=%b int=%b insvc=%b want 0 0 0000", busy, interrupt, in_service);
        end
        pulse(4'b0010);
        cyc(); cyc(); cyc();
        op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        n_tests++;
        if (interrupt !== 1'b1 || busy !== 1'b1 || active_id !== 2'd1 || in_service !== 4'h0) begin
            n_fail++;
            $display("FAIL stray_reti_in_req: int=%b busy=%b id=%0d insvc=%b want 1 1 1 0000",
                     interrupt, busy, active_id, in_service);
        end
        int_ack = 1'b1;
        cyc();
        op = 6'h15; op_valid = 1'b1;
        cyc();
        int_ack = 1'b0; op_valid = 1'b0; op = 6'h00;
        n_tests++;
        if (busy !== 1'b1 || in_service !== 4'b0010 || interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_in_service: busy=%b insvc=%b int=%b want 1 0010 0", busy, in_service, interrupt);
        end
        op = 6'h3F; op_valid = 1'b1;
        cyc();
        op_valid = 1'b0; op = 6'h00;
        cyc();
    endtask

    task automatic test_reset_mid_service();
        pulse(4'b0100);
        cyc(); cyc(); cyc();
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        pulse(4'b0001);
        cyc(); cyc();
        n_tests++;
        if (busy !== 1'b1 || in_service !== 4'b0100 || pending !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_setup: busy=%b insvc=%b pending=%b want 1 0100 0001", busy, in_service, pending);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({interrupt, isr_addr, active_id, pending, mask, in_service, busy} !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 0",
                     {interrupt, isr_addr, active_id, pending, mask, in_service, busy});
        end
        cyc();
        reset = 1'b0;
        cyc();
        n_tests++;
        if (busy !== 1'b0 || pending !== 4'h0 || interrupt !== 1'b0 || mask !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_after: busy=%b pending=%b int=%b mask=%b want 0 0 0 0",
                     busy, pending, interrupt, mask);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        for (int c = 0; c < 3000; c++) begin
            got = {interrupt, isr_addr, active_id, pending, mask, in_service, busy};
            exp = {m_int, m_addr, m_id, m_pending, m_mask, m_insvc, (m_req | m_isr)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", c, got, exp);
            end
            irq_in    = irq_in ^ 4'($urandom & $urandom);
            mask_wr   = ($urandom_range(0, 7) == 0);
            mask_data = 4'($urandom);
            int_ack   = ($urandom_range(0, 2) == 0);
            op_valid  = ($urandom_range(0, 2) == 0);
            op        = $urandom_range(0, 1) ? 6'h3F : 6'($urandom);
            cyc();
        end
        irq_in = 4'h0; mask_wr = 1'b0; int_ack = 1'b0; op_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'h0; mask_wr = 1'b0; mask_data = 4'h0;
        op = 6'h00; op_valid = 1'b0; int_ack = 1'b0;
        cyc(); cyc();
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_no_preempt();
        test_simultaneous();
        test_stray();
        test_reset_mid_service();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
